exe_stage_multislot: RTL and testbench

//  Parametrised execute stage for the N-issue MIPS pipeline. It sits between the ID/EX and EX/MEM registers.
//  Per slot: forwards operands from the EX/MEM, MEM and WB stages, runs a simple ALU, and registers the results

---
 rtl/exe_stage_multislot.sv | 184 ++++++++++++++++++
 tb/tb_exe_stage_multislot.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_multislot.sv
// exe_stage_multislot: N-issue MIPS execute stage with operand forwarding, per-slot ALU,
// shared iterative MULTU/DIVU unit with HI/LO, and the EX/MEM pipeline register.
// Ports: CLK/RESET (sync, active-high)/FREEZE; per-slot packed operands, specifiers, alu_ctl,
// controls, MEM and WB writeback buses in; registered *_pr results/controls and md_stall out.
// Define EXE_FWD_WB_EN to let the WB bus forward; otherwise the WB ports are ignored.
module exe_stage_multislot #(
    parameter int DATA_W = 32,
    parameter int NSLOT  = 2,
    parameter int REG_AW = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FREEZE,
    input  logic [NSLOT*DATA_W-1:0] op_a,
    input  logic [NSLOT*DATA_W-1:0] op_b,
    input  logic [NSLOT-1:0]        alusrc,
    input  logic [NSLOT*REG_AW-1:0] ra_a,
    input  logic [NSLOT*REG_AW-1:0] ra_b,
    input  logic [NSLOT*5-1:0]      shamt,
    input  logic [NSLOT*4-1:0]      alu_ctl,
    input  logic [NSLOT*REG_AW-1:0] wr_reg,
    input  logic [NSLOT-1:0]        wr_en,
    input  logic [NSLOT-1:0]        mem_rd,
    input  logic [NSLOT-1:0]        mem_wr,
    input  logic [NSLOT-1:0]        mem_fwd_en,
    input  logic [NSLOT*REG_AW-1:0] mem_fwd_reg,
    input  logic [NSLOT*DATA_W-1:0] mem_fwd_data,
    input  logic [NSLOT-1:0]        wb_fwd_en,
    input  logic [NSLOT*REG_AW-1:0] wb_fwd_reg,
    input  logic [NSLOT*DATA_W-1:0] wb_fwd_data,
    output logic [NSLOT*DATA_W-1:0] alu_res_pr,
    output logic [NSLOT*DATA_W-1:0] store_pr,
    output logic [NSLOT*REG_AW-1:0] wr_reg_pr,
    output logic [NSLOT-1:0]        wr_en_pr,
    output logic [NSLOT-1:0]        mem_rd_pr,
    output logic [NSLOT-1:0]        mem_wr_pr,
    output logic                    md_stall
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                           OP_MFHI = 4'd8, OP_MFLO = 4'd9, OP_MULTU = 4'd10, OP_DIVU = 4'd11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] fa [NSLOT];
    logic [DATA_W-1:0] fb [NSLOT];
    logic [DATA_W-1:0] fs [NSLOT];
    logic [DATA_W-1:0] res [NSLOT];
    logic [NSLOT-1:0]  is_md, is_mf;
    logic [REG_AW-1:0] ra, rb;
    logic [3:0]        ctl;
    logic [4:0]        sa;
    logic [DATA_W-1:0] hi, lo, md_a, md_b, md_d;
    logic              md_div, md_go, dge;
    logic [CW-1:0]     cnt;
    logic [DATA_W:0]   msum, dsh;

`ifndef EXE_FWD_WB_EN
    logic unused_wb;
    assign unused_wb = ^{wb_fwd_en, wb_fwd_reg, wb_fwd_data};
`endif

    // Forwarding stages are applied oldest-first so later assignments take priority:
    // WB, then MEM, then our own EX/MEM register; ascending slot order lets the youngest win.
    always_comb begin
        ra = '0;
        rb = '0;
        ctl = '0;
        sa = '0;
        is_md = '0;
        is_mf = '0;
        for (int s = 0; s < NSLOT; s++) begin
            ra = ra_a[s*REG_AW +: REG_AW];
            rb = ra_b[s*REG_AW +: REG_AW];
            ctl = alu_ctl[s*4 +: 4];
            sa = shamt[s*5 +: 5];
            fa[s] = op_a[s*DATA_W +: DATA_W];
            fs[s] = op_b[s*DATA_W +: DATA_W];
`ifdef EXE_FWD_WB_EN
            for (int k = 0; k < NSLOT; k++) begin
                if (wb_fwd_en[k] && ra != '0 && wb_fwd_reg[k*REG_AW +: REG_AW] == ra) fa[s] = wb_fwd_data[k*DATA_W +: DATA_W];
                if (wb_fwd_en[k] && rb != '0 && wb_fwd_reg[k*REG_AW +: REG_AW] == rb) fs[s] = wb_fwd_data[k*DATA_W +: DATA_W];
            end
`endif
            for (int k = 0; k < NSLOT; k++) begin
                if (mem_fwd_en[k] && ra != '0 && mem_fwd_reg[k*REG_AW +: REG_AW] == ra) fa[s] = mem_fwd_data[k*DATA_W +: DATA_W];
                if (mem_fwd_en[k] && rb != '0 && mem_fwd_reg[k*REG_AW +: REG_AW] == rb) fs[s] = mem_fwd_data[k*DATA_W +: DATA_W];
            end
            for (int k = 0; k < NSLOT; k++) begin
                if (wr_en_pr[k] && ra != '0 && wr_reg_pr[k*REG_AW +: REG_AW] == ra) fa[s] = alu_res_pr[k*DATA_W +: DATA_W];
                if (wr_en_pr[k] && rb != '0 && wr_reg_pr[k*REG_AW +: REG_AW] == rb) fs[s] = alu_res_pr[k*DATA_W +: DATA_W];
            end
            fb[s] = alusrc[s] ? op_b[s*DATA_W +: DATA_W] : fs[s];
            is_md[s] = ctl == OP_MULTU || ctl == OP_DIVU;
            is_mf[s] = ctl == OP_MFHI || ctl == OP_MFLO;
            case (ctl)
                OP_ADD:  res[s] = fa[s] + fb[s];
                OP_SUB:  res[s] = fa[s] - fb[s];
                OP_AND:  res[s] = fa[s] & fb[s];
                OP_OR:   res[s] = fa[s] | fb[s];
                OP_XOR:  res[s] = fa[s] ^ fb[s];
                OP_SLT:  res[s] = {{(DATA_W-1){1'b0}}, $signed(fa[s]) < $signed(fb[s])};
                OP_SLL:  res[s] = fb[s] << sa;
                OP_SRL:  res[s] = fb[s] >> sa;
                OP_MFHI: res[s] = hi;
                OP_MFLO: res[s] = lo;
                default: res[s] = '0;
            endcase
        end
    end

    // While a stalled op waits to be re-presented the whole bundle becomes a bubble.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_res_pr <= '0;
            store_pr <= '0;
            wr_reg_pr <= '0;
            wr_en_pr <= '0;
            mem_rd_pr <= '0;
            mem_wr_pr <= '0;
        end else if (!FREEZE) begin
            for (int s = 0; s < NSLOT; s++) begin
                alu_res_pr[s*DATA_W +: DATA_W] <= res[s];
                store_pr[s*DATA_W +: DATA_W] <= fs[s];
            end
            wr_reg_pr <= wr_reg;
            wr_en_pr <= md_stall ? '0 : wr_en & ~is_md;
            mem_rd_pr <= md_stall ? '0 : mem_rd;
            mem_wr_pr <= md_stall ? '0 : mem_wr;
        end
    end

    assign md_go = state == IDLE && !FREEZE && is_md[0];

    always_ff @(posedge CLK) state <= RESET ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = md_go ? BUSY : IDLE;
            BUSY:    state_n = cnt == CW'(DATA_W-1) ? DONE : BUSY;
            default: state_n = IDLE;
        endcase
    end

    always_comb md_stall = state != IDLE && |(is_md | is_mf);

    // md_a is the running high half / partial remainder, md_b the multiplier / quotient,
    // so DONE writes HI/LO identically for both operations.
    assign msum = {1'b0, md_a} + (md_b[0] ? {1'b0, md_d} : '0);
    assign dsh = {md_a, md_b[DATA_W-1]};
    assign dge = dsh >= {1'b0, md_d};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hi <= '0;
            lo <= '0;
            md_a <= '0;
            md_b <= '0;
            md_d <= '0;
            md_div <= 1'b0;
            cnt <= '0;
        end else if (md_go) begin
            md_div <= alu_ctl[3:0] == OP_DIVU;
            md_a <= '0;
            md_b <= alu_ctl[3:0] == OP_DIVU ? fa[0] : fb[0];
            md_d <= alu_ctl[3:0] == OP_DIVU ? fb[0] : fa[0];
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (md_div) begin
                md_a <= dge ? dsh[DATA_W-1:0] - md_d : dsh[DATA_W-1:0];
                md_b <= {md_b[DATA_W-2:0], dge};
            end else begin
                {md_a, md_b} <= {msum, md_b[DATA_W-1:1]};
            end
        end else if (state == DONE) begin
            hi <= md_a;
            lo <= md_b;
        end
    end
endmodule

// File: tb/tb_exe_stage_multislot.sv
// tb_exe_stage_multislot: directed vectors and multi-cycle sequences for exe_stage_multislot.
module tb_exe_stage_multislot;
    localparam int W = 32, N = 2, RA = 5;
    localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLT = 5, SLL = 6, SRL = 7,
                           MFHI = 8, MFLO = 9, MULTU = 10, DIVU = 11;

    logic CLK = 1'b0, RESET, FREEZE;
    logic [N*W-1:0] op_a, op_b, mem_fwd_data, wb_fwd_data, alu_res_pr, store_pr;
    logic [N-1:0] alusrc, wr_en, mem_rd, mem_wr, mem_fwd_en, wb_fwd_en, wr_en_pr, mem_rd_pr, mem_wr_pr;
    logic [N*RA-1:0] ra_a, ra_b, wr_reg, mem_fwd_reg, wb_fwd_reg, wr_reg_pr;
    logic [N*5-1:0] shamt;
    logic [N*4-1:0] alu_ctl;
    logic md_stall;
    int checks = 0, errors = 0;

    exe_stage_multislot dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .op_a(op_a), .op_b(op_b), .alusrc(alusrc),
        .ra_a(ra_a), .ra_b(ra_b), .shamt(shamt), .alu_ctl(alu_ctl), .wr_reg(wr_reg), .wr_en(wr_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_fwd_en(mem_fwd_en), .mem_fwd_reg(mem_fwd_reg),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg),
        .wb_fwd_data(wb_fwd_data), .alu_res_pr(alu_res_pr), .store_pr(store_pr),
        .wr_reg_pr(wr_reg_pr), .wr_en_pr(wr_en_pr), .mem_rd_pr(mem_rd_pr), .mem_wr_pr(mem_wr_pr),
        .md_stall(md_stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] c0, c1;
        logic [W-1:0] a0, b0, a1, b1;
        logic [4:0] s0, s1;
        logic [W-1:0] e0, e1;
        logic [1:0] we;
        logic m1;
    } vec_t;
    vec_t tv [9];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr;
        FREEZE = 0; op_a = 0; op_b = 0; alusrc = 0; ra_a = 0; ra_b = 0; shamt = 0; alu_ctl = 0;
        wr_reg = 0; wr_en = 0; mem_rd = 0; mem_wr = 0; mem_fwd_en = 0; mem_fwd_reg = 0;
        mem_fwd_data = 0; wb_fwd_en = 0; wb_fwd_reg = 0; wb_fwd_data = 0;
    endtask

    task automatic slot(input int s, input logic [3:0] c, input logic [W-1:0] a, b,
                        input logic [RA-1:0] rs, rt, rd, input logic we);
        alu_ctl[s*4 +: 4] = c;
        op_a[s*W +: W] = a;
        op_b[s*W +: W] = b;
        ra_a[s*RA +: RA] = rs;
        ra_b[s*RA +: RA] = rt;
        wr_reg[s*RA +: RA] = rd;
        wr_en[s] = we;
    endtask

    task automatic do_md(input string nm, input logic [3:0] c, input logic [W-1:0] a, b, hi_e, lo_e,
                         input logic frz);
        int n;
        clr; slot(0, c, a, b, 0, 0, 9, 1); tick;
        chk({nm, " issue wr_en_pr"}, W'(wr_en_pr), 0);
        clr; slot(0, MFHI, 0, 0, 0, 0, 7, 1); FREEZE = frz; #1;
        n = 0;
        while (md_stall && n < 100) begin
            tick;
            n++;
        end
        chk({nm, " stall cycles"}, W'(n), 33);
        chk({nm, " bubble wr_en_pr"}, W'(wr_en_pr), 0);
        FREEZE = 0; tick;
        chk({nm, " HI"}, alu_res_pr[W-1:0], hi_e);
        chk({nm, " mfhi wr_en_pr"}, W'(wr_en_pr), 1);
        slot(0, MFLO, 0, 0, 0, 0, 7, 1); tick;
        chk({nm, " LO"}, alu_res_pr[W-1:0], lo_e);
    endtask

    initial begin
        tv[0] = '{ADD, SUB, 5, 7, 5, 7, 0, 0, 12, 32'hFFFF_FFFE, 2'b11, 1};
        tv[1] = '{AND_, OR_, 32'hF0F0, 32'hFF00, 32'hF0F0, 32'h0F0F, 0, 0, 32'hF000, 32'hFFFF, 2'b11, 1};
        tv[2] = '{XOR_, SLT, 32'hFF, 32'h0F, 32'hFFFF_FFFF, 1, 0, 0, 32'hF0, 1, 2'b11, 1};
        tv[3] = '{SLT, SLL, 1, 32'hFFFF_FFFF, 0, 1, 0, 31, 0, 32'h8000_0000, 2'b11, 1};
        tv[4] = '{SRL, ADD, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 31, 0, 1, 0, 2'b11, 1};
        tv[5] = '{SUB, SLT, 0, 1, 5, 5, 0, 0, 32'hFFFF_FFFF, 0, 2'b11, 1};
        tv[6] = '{SRL, SLL, 0, 32'h1234_5678, 0, 32'h1234_5678, 4, 4, 32'h0123_4567, 32'h2345_6780, 2'b11, 1};
        tv[7] = '{MFHI, MFLO, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1};
        tv[8] = '{ADD, MULTU, 1, 1, 3, 4, 0, 0, 2, 0, 2'b01, 0};

        // reset with random inputs
        RESET = 1; FREEZE = 0;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; alusrc = 2'($urandom);
        ra_a = 10'($urandom); ra_b = 10'($urandom); shamt = 10'($urandom); alu_ctl = 8'($urandom);
        wr_reg = 10'($urandom); wr_en = 2'b11; mem_rd = 2'b11; mem_wr = 2'b11;
        mem_fwd_en = 2'($urandom); mem_fwd_reg = 10'($urandom); mem_fwd_data = {$urandom, $urandom};
        wb_fwd_en = 2'($urandom); wb_fwd_reg = 10'($urandom); wb_fwd_data = {$urandom, $urandom};
        tick; tick;
        chk("rst alu_res_pr lo", alu_res_pr[W-1:0], 0);
        chk("rst alu_res_pr hi", alu_res_pr[2*W-1:W], 0);
        chk("rst store_pr", store_pr[W-1:0] | store_pr[2*W-1:W], 0);
        chk("rst wr_reg_pr", W'(wr_reg_pr), 0);
        chk("rst wr_en_pr", W'(wr_en_pr), 0);
        chk("rst mem_rd/wr_pr", W'({mem_rd_pr, mem_wr_pr}), 0);
        chk("rst md_stall", W'(md_stall), 0);
        clr; RESET = 0;

        // single-cycle ALU vectors, no forwarding (all specifiers r0)
        for (int i = 0; i < 9; i++) begin
            clr;
            slot(0, tv[i].c0, tv[i].a0, tv[i].b0, 0, 0, 0, 1);
            slot(1, tv[i].c1, tv[i].a1, tv[i].b1, 0, 0, 0, 1);
            shamt = {tv[i].s1, tv[i].s0};
            tick;
            chk($sformatf("vec%0d slot0", i), alu_res_pr[W-1:0], tv[i].e0);
            if (tv[i].m1) chk($sformatf("vec%0d slot1", i), alu_res_pr[2*W-1:W], tv[i].e1);
            chk($sformatf("vec%0d wr_en_pr", i), W'(wr_en_pr), W'(tv[i].we));
        end

        // EX/MEM forward beats MEM bus
        clr; slot(0, ADD, 5, 7, 1, 2, 3, 1); tick;
        chk("add r3", alu_res_pr[W-1:0], 12);
        clr; slot(1, SUB, 0, 5, 3, 1, 4, 1);
        mem_fwd_en = 2'b01; mem_fwd_reg[RA-1:0] = 3; mem_fwd_data[W-1:0] = 32'h99; tick;
        chk("exmem fwd sub", alu_res_pr[2*W-1:W], 7);
        chk("sub store", store_pr[2*W-1:W], 5);
        chk("sub wr_reg_pr", W'(wr_reg_pr[2*RA-1:RA]), 4);
        chk("sub wr_en_pr", W'(wr_en_pr), 2);

        // FREEZE holds EX/MEM; controls pass through
        clr; slot(0, ADD, 1, 2, 0, 0, 0, 1); mem_rd = 2'b01; mem_wr = 2'b10; tick;
        chk("pass mem_rd", W'(mem_rd_pr), 1);
        chk("pass mem_wr", W'(mem_wr_pr), 2);
        clr; slot(0, ADD, 10, 20, 0, 0, 0, 1); FREEZE = 1; tick;
        chk("freeze hold", alu_res_pr[W-1:0], 3);
        chk("freeze hold mem_rd", W'(mem_rd_pr), 1);
        FREEZE = 0; tick;
        chk("unfreeze", alu_res_pr[W-1:0], 30);

        // MEM bus: youngest slot wins; r0 never forwarded; immediates not forwarded but store is
        clr; tick;
        slot(0, ADD, 1, 0, 6, 0, 0, 0);
        slot(1, ADD, 3, 32'h100, 0, 6, 0, 0); alusrc = 2'b10;
        mem_fwd_en = 2'b11; mem_fwd_reg = {5'd6, 5'd6}; mem_fwd_data = {32'h22, 32'h11}; tick;
        chk("mem youngest", alu_res_pr[W-1:0], 32'h22);
        chk("imm no fwd", alu_res_pr[2*W-1:W], 32'h103);
        chk("store fwd imm", store_pr[2*W-1:W], 32'h22);
        clr; slot(0, ADD, 1, 0, 0, 0, 0, 0);
        mem_fwd_en = 2'b11; mem_fwd_data = {32'h22, 32'h11}; tick;
        chk("r0 no fwd", alu_res_pr[W-1:0], 1);

        // WB bus forwarding depends on configuration; MEM beats WB in either case
        clr; slot(0, ADD, 1, 0, 5, 0, 0, 0);
        wb_fwd_en = 2'b01; wb_fwd_reg[RA-1:0] = 5; wb_fwd_data[W-1:0] = 32'hAB; tick;
`ifdef EXE_FWD_WB_EN
        chk("wb fwd", alu_res_pr[W-1:0], 32'hAB);
`else
        chk("wb ignored", alu_res_pr[W-1:0], 1);
`endif
        mem_fwd_en = 2'b10; mem_fwd_reg[2*RA-1:RA] = 5; mem_fwd_data[2*W-1:W] = 32'hCD; tick;
        chk("mem over wb", alu_res_pr[W-1:0], 32'hCD);

        // multiply / divide
        do_md("multu", MULTU, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFE, 0);
        do_md("divu", DIVU, 100, 7, 2, 14, 0);
        do_md("divu0", DIVU, 9, 0, 9, 32'hFFFF_FFFF, 1);

        // reset aborts a divide in flight
        clr; RESET = 1; tick; RESET = 0;
        slot(0, DIVU, 100, 7, 0, 0, 0, 1); tick;
        clr; repeat (10) tick;
        RESET = 1; tick; RESET = 0;
        slot(0, MFHI, 0, 0, 0, 0, 7, 1); #1;
        chk("abort md_stall", W'(md_stall), 0);
        clr; repeat (40) tick;
        slot(0, MFHI, 0, 0, 0, 0, 7, 1); tick;
        chk("abort HI", alu_res_pr[W-1:0], 0);
        slot(0, MFLO, 0, 0, 0, 0, 7, 1); tick;
        chk("abort LO", alu_res_pr[W-1:0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
